// File: rtl/ubpipe_rca.sv
// Pipelined unsigned ripple-carry adder/subtractor: the carry chain is cut into
// STAGES ripple segments, each followed by a register with valid/ready flow control.
module ubpipe_rca #(
  parameter int WIDTH  = 27,
  parameter int STAGES = 3
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             CI,
  input  logic             SUB,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH:0]   S
);

  // Low bit index of segment k; the first WIDTH%STAGES segments get one extra bit.
  function automatic int seg_lo(input int k);
    int base;
    int rem;
    base = WIDTH / STAGES;
    rem  = WIDTH % STAGES;
    return k * base + ((k < rem) ? k : rem);
  endfunction

  logic [STAGES-1:0] valid_q, valid_d;
  logic [STAGES-1:0] c_q, c_d;
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic [WIDTH-1:0]  sum_d [STAGES];
  logic [WIDTH-1:0]  x_q   [STAGES];
  logic [WIDTH-1:0]  x_d   [STAGES];
  logic [WIDTH-1:0]  y_q   [STAGES];
  logic [WIDTH-1:0]  y_d   [STAGES];
  logic [STAGES:0]   stg_ready;

  logic [WIDTH-1:0]  x_t, y_t, s_t;
  logic              c_t, v_t;
  int                kp;

  always_comb begin
    stg_ready[STAGES] = OUT_READY;
    for (int k = STAGES - 1; k >= 0; k--) begin
      stg_ready[k] = !valid_q[k] || stg_ready[k+1];
    end

    x_t = '0;
    y_t = '0;
    s_t = '0;
    c_t = 1'b0;
    v_t = 1'b0;
    kp  = 0;
    for (int k = 0; k < STAGES; k++) begin
      kp = (k == 0) ? 0 : k - 1;
      if (k == 0) begin
        // Subtract is X + ~Y + !CI; the inversion happens once, at capture.
        x_t = X;
        y_t = SUB ? ~Y : Y;
        s_t = '0;
        c_t = CI ^ SUB;
        v_t = IN_VALID;
      end else begin
        x_t = x_q[kp];
        y_t = y_q[kp];
        s_t = sum_q[kp];
        c_t = c_q[kp];
        v_t = valid_q[kp];
      end

      for (int i = 0; i < WIDTH; i++) begin
        if (i >= seg_lo(k) && i < seg_lo(k + 1)) begin
          s_t[i] = x_t[i] ^ y_t[i] ^ c_t;
          c_t    = (x_t[i] & y_t[i]) | (x_t[i] & c_t) | (y_t[i] & c_t);
          x_t[i] = 1'b0;
          y_t[i] = 1'b0;
        end
      end

      if (stg_ready[k]) begin
        valid_d[k] = v_t;
        c_d[k]     = c_t;
        sum_d[k]   = s_t;
        x_d[k]     = x_t;
        y_d[k]     = y_t;
      end else begin
        valid_d[k] = valid_q[k];
        c_d[k]     = c_q[k];
        sum_d[k]   = sum_q[k];
        x_d[k]     = x_q[k];
        y_d[k]     = y_q[k];
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      valid_q <= '0;
      c_q     <= '0;
      for (int k = 0; k < STAGES; k++) begin
        sum_q[k] <= '0;
        x_q[k]   <= '0;
        y_q[k]   <= '0;
      end
    end else begin
      valid_q <= valid_d;
      c_q     <= c_d;
      for (int k = 0; k < STAGES; k++) begin
        sum_q[k] <= sum_d[k];
        x_q[k]   <= x_d[k];
        y_q[k]   <= y_d[k];
      end
    end
  end

  assign IN_READY  = stg_ready[0];
  assign OUT_VALID = valid_q[STAGES-1];
  assign S         = {c_q[STAGES-1], sum_q[STAGES-1]};

endmodule

// File: tb/tb_ubpipe_rca.sv
// Directed and swept checks of ubpipe_rca: latency, handshake, backpressure,
// bubble collapse, asynchronous reset and exact results against a reference.
module tb_ubpipe_rca;
  localparam int W  = 27;
  localparam int ST = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] x = '0;
  logic [W-1:0] y = '0;
  logic         ci = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W:0]   s;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic sweep_go = 1'b0;
  int sweep_done = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ubpipe_rca #(.WIDTH(W), .STAGES(ST)) dut (
    .CLK(clk), .RSTn(rst_n), .IN_VALID(in_valid), .IN_READY(in_ready),
    .X(x), .Y(y), .CI(ci), .SUB(sub),
    .OUT_VALID(out_valid), .OUT_READY(out_ready), .S(s)
  );

  // Reference: arithmetic difference plus an explicit comparison for the no-borrow flag.
  function automatic logic [W:0] ref_rca(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic c, input logic sb);
    logic [W:0] d;
    logic       ge;
    d  = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, c};
    ge = ({1'b0, a} >= ({1'b0, b} + {{W{1'b0}}, c}));
    if (sb) return {ge, d[W-1:0]};
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
  endfunction

  task automatic wait_valid(input int max_cyc, output bit got);
    got = 1'b0;
    for (int n = 0; n < max_cyc; n++) begin
      if (out_valid) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b expected 0", out_valid); end
    checks++; if (s !== '0) begin errors++; $display("FAIL reset s: got %h expected 0", s); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready: got %b expected 1", in_ready); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_max_add();
    int acc;
    bit got;
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; x = 27'h7FFFFFF; y = '0; ci = 1'b1; sub = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL max_add in_ready: got %b expected 1", in_ready); end
    acc = cyc + 1;
    @(negedge clk);
    in_valid = 1'b0; x = '0;
    wait_valid(10, got);
    checks++;
    if (!got) begin
      errors++; $display("FAIL max_add timeout: out_valid got 0 expected 1");
    end else begin
      checks++; if (s !== 28'h8000000) begin errors++; $display("FAIL max_add s: got %h expected 8000000", s); end
      checks++; if (cyc - acc + 1 != 3) begin errors++; $display("FAIL max_add latency: got %0d expected 3", cyc - acc + 1); end
    end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL max_add duplicate: out_valid got %b expected 0", out_valid); end
  endtask

  task automatic test_sub_b2b();
    bit got;
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; x = 5; y = 7; ci = 1'b0; sub = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL sub_b2b in_ready0: got %b expected 1", in_ready); end
    @(negedge clk);
    x = 7; y = 5;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL sub_b2b in_ready1: got %b expected 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0; sub = 1'b0; x = 27'h1234; y = 27'h99;
    wait_valid(10, got);
    checks++;
    if (!got) begin
      errors++; $display("FAIL sub_b2b timeout: out_valid got 0 expected 1");
    end else begin
      checks++; if (s !== 28'h7FFFFFE) begin errors++; $display("FAIL sub_b2b first: got %h expected 7fffffe", s); end
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || s !== 28'h8000002) begin
        errors++; $display("FAIL sub_b2b second: valid %b s %h expected valid 1 s 8000002", out_valid, s);
      end
    end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sub_b2b drain: out_valid got %b expected 0", out_valid); end
  endtask

  task automatic test_backpressure();
    logic [W:0]   q[$];
    logic [W:0]   exp_s;
    logic [W:0]   held;
    logic [W-1:0] bx, by;
    logic         bci, bsub;
    logic [31:0]  r;
    bit           stall, dropped;
    int           cnt, acc, got;
    cnt = 0; acc = 0; got = 0; stall = 1'b0; dropped = 1'b0; held = '0;
    r = $urandom; bx = r[W-1:0];
    r = $urandom; by = r[W-1:0]; bci = r[30]; bsub = r[31];
    for (int t = 0; t < 300 && (acc < 10 || q.size() > 0); t++) begin
      @(negedge clk);
      out_ready = (t % 4 == 0) || (t % 4 == 3);
      in_valid  = (acc < 10);
      x = bx; y = by; ci = bci; sub = bsub;
      #1;
      checks++; if (in_ready !== ((cnt < 3) || out_ready)) begin
        errors++; $display("FAIL bp in_ready t=%0d: got %b expected %b", t, in_ready, (cnt < 3) || out_ready);
      end
      if (!in_ready) dropped = 1'b1;
      if (stall) begin
        checks++; if (out_valid !== 1'b1 || s !== held) begin
          errors++; $display("FAIL bp stall hold t=%0d: valid %b s %h expected valid 1 s %h", t, out_valid, s, held);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL bp extra result: got %h expected none", s);
        end else begin
          exp_s = q.pop_front();
          if (s !== exp_s) begin errors++; $display("FAIL bp result %0d: got %h expected %h", got, s, exp_s); end
        end
        cnt--; got++;
      end
      stall = out_valid && !out_ready;
      held  = s;
      if (in_valid && in_ready) begin
        q.push_back(ref_rca(bx, by, bci, bsub));
        cnt++; acc++;
        r = $urandom; bx = r[W-1:0];
        r = $urandom; by = r[W-1:0]; bci = r[30]; bsub = r[31];
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (got != 10 || q.size() != 0) begin
      errors++; $display("FAIL bp count: delivered %0d pending %0d expected 10 and 0", got, q.size());
    end
    checks++; if (!dropped) begin errors++; $display("FAIL bp no_drop: in_ready low seen 0 expected 1"); end
  endtask

  task automatic test_bubble();
    logic [W:0] exp_s [3];
    int k;
    exp_s[0] = 28'd123; exp_s[1] = 28'd4; exp_s[2] = 28'h7FFFFF5;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; x = 100; y = 23; ci = 1'b0; sub = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bubble first in_ready: got %b expected 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    in_valid = 1'b1; x = 1; y = 2; ci = 1'b1; sub = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
      errors++; $display("FAIL bubble second: in_ready %b out_valid %b expected 1 1", in_ready, out_valid);
    end
    @(negedge clk);
    x = 50; y = 60; ci = 1'b1; sub = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bubble third in_ready: got %b expected 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0; sub = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bubble full in_ready: got %b expected 0", in_ready); end
    out_ready = 1'b1;
    k = 0;
    for (int n = 0; n < 20 && k < 3; n++) begin
      if (out_valid) begin
        checks++; if (s !== exp_s[k]) begin errors++; $display("FAIL bubble result %0d: got %h expected %h", k, s, exp_s[k]); end
        k++;
      end
      @(negedge clk);
    end
    checks++; if (k != 3 || out_valid !== 1'b0) begin
      errors++; $display("FAIL bubble drain: results %0d out_valid %b expected 3 0", k, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    bit stale, got;
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; x = 1; y = 1; ci = 1'b0; sub = 1'b0;
    @(negedge clk); x = 2;
    @(negedge clk); x = 3;
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++; $display("FAIL rst_mid full: in_ready %b out_valid %b expected 0 1", in_ready, out_valid);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid out_valid: got %b expected 0", out_valid); end
    checks++; if (s !== '0) begin errors++; $display("FAIL rst_mid s: got %h expected 0", s); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid in_ready: got %b expected 1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    stale = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) stale = 1'b1;
    end
    checks++; if (stale) begin errors++; $display("FAIL rst_mid stale: out_valid seen 1 expected 0"); end
    in_valid = 1'b1; x = 10; y = 20; ci = 1'b0; sub = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    wait_valid(10, got);
    checks++; if (!got || s !== 28'd30) begin
      errors++; $display("FAIL rst_mid fresh: valid %b s %h expected 1 1e", got, s);
    end
    @(negedge clk);
  endtask

  task automatic test_sweep();
    sweep_go = 1'b1;
    for (int n = 0; n < 20000 && sweep_done < 12; n++) @(negedge clk);
    checks++; if (sweep_done != 12) begin
      errors++; $display("FAIL sweep timeout: finished %0d expected 12", sweep_done);
    end
  endtask

  // Sweep configurations; STAGES=4 is clamped to WIDTH when WIDTH is smaller.
  for (genvar gw = 0; gw < 4; gw++) begin : g_w
    for (genvar gs = 0; gs < 3; gs++) begin : g_s
      localparam int SW = (gw == 0) ? 2 : (gw == 1) ? 9 : (gw == 2) ? 27 : 64;
      localparam int SS = (gs == 0) ? 1 : (gs == 1) ? ((SW < 4) ? SW : 4) : SW;
      logic          iv, ir, c_i, sb, ov, orr;
      logic [SW-1:0] a, b;
      logic [SW:0]   r;

      ubpipe_rca #(.WIDTH(SW), .STAGES(SS)) u_dut (
        .CLK(clk), .RSTn(rst_n), .IN_VALID(iv), .IN_READY(ir),
        .X(a), .Y(b), .CI(c_i), .SUB(sb),
        .OUT_VALID(ov), .OUT_READY(orr), .S(r)
      );

      initial begin
        logic [SW:0] expq[$];
        int          accq[$];
        logic [SW:0] e, d;
        logic        ge;
        logic [63:0] rnd;
        logic [31:0] r3;
        int          sent, acc;
        iv = 1'b0; a = '0; b = '0; c_i = 1'b0; sb = 1'b0; orr = 1'b1;
        sent = 0;
        wait (sweep_go);
        for (int t = 0; t < 5000 && (sent < 1000 || expq.size() > 0); t++) begin
          @(negedge clk);
          if (ov) begin
            checks++;
            if (expq.size() == 0) begin
              errors++; $display("FAIL sweep W=%0d S=%0d extra: got %h expected none", SW, SS, r);
            end else begin
              e = expq.pop_front();
              acc = accq.pop_front();
              if (r !== e || cyc - acc + 1 != SS) begin
                errors++;
                $display("FAIL sweep W=%0d S=%0d: got %h lat %0d expected %h lat %0d", SW, SS, r, cyc - acc + 1, e, SS);
              end
            end
          end
          rnd = {$urandom, $urandom}; a = rnd[SW-1:0];
          rnd = {$urandom, $urandom}; b = rnd[SW-1:0];
          r3 = $urandom;
          c_i = r3[0]; sb = r3[1];
          iv = (sent < 1000) && (r3[4:2] != 3'd0);
          #1;
          if (iv && ir) begin
            d  = {1'b0, a} - {1'b0, b} - {{SW{1'b0}}, c_i};
            ge = ({1'b0, a} >= ({1'b0, b} + {{SW{1'b0}}, c_i}));
            e  = sb ? {ge, d[SW-1:0]} : ({1'b0, a} + {1'b0, b} + {{SW{1'b0}}, c_i});
            expq.push_back(e);
            accq.push_back(cyc + 1);
            sent++;
          end
        end
        iv = 1'b0;
        checks++; if (sent != 1000 || expq.size() != 0) begin
          errors++; $display("FAIL sweep W=%0d S=%0d count: sent %0d pending %0d expected 1000 0", SW, SS, sent, expq.size());
        end
        sweep_done++;
      end
    end
  end

  initial begin
    test_reset();
    test_max_add();
    test_sub_b2b();
    test_backpressure();
    test_bubble();
    test_reset_mid();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ubpipe_rca.md
# ubpipe_rca

Parametrised, pipelined unsigned ripple-carry adder/subtractor with valid/ready handshakes on both sides. The WIDTH-bit carry chain is split into STAGES ripple segments, with one register stage after each segment. This bounds the combinational ripple depth per cycle while sustaining one operation per clock. It serves as the sequential, mode-capable successor of the fixed-width combinational ripple-carry adders in the arithmetic library.

## Interface
- WIDTH, default 27: operand width in bits; legal values are 2 or more.
- STAGES, default 3: number of ripple segments and pipeline registers; legal range is 1..WIDTH.
- CLK  in  1  rising-edge clock; the block's only clock.
- RSTn  in  1  reset, asynchronous and active-low.
- IN_VALID  in  1  operand beat valid.
- IN_READY  out  1  block accepts a beat this cycle.
- X  in  WIDTH  operand 1.
- Y  in  WIDTH  operand 2.
- CI  in  1  carry-in (ADD) or borrow-in (SUB).
- SUB  in  1  0 selects add; 1 selects subtract.
- OUT_VALID  out  1  result valid.
- OUT_READY  in  1  consumer accepts the result.
- S  out  WIDTH+1  result; S[WIDTH] is the carry-out, or the no-borrow flag in SUB mode.

## Operation
- ADD: S = X + Y + CI, exact, WIDTH+1 bits.
- SUB: S = X + ~Y + !CI, i.e. X − Y − CI mod 2^WIDTH in S[WIDTH-1:0].
  - S[WIDTH] = 1 when no borrow occurred, i.e. X ≥ Y + CI.
- Segment widths, for i = 0 (LSB) .. STAGES-1: WIDTH/STAGES + (i < WIDTH%STAGES ? 1 : 0). Every segment is therefore at least 1 bit.
- Segment i is a ripple of full-adder cells with majority carry and XOR sum. Its carry-in is the registered carry-out of segment i-1; segment 0 takes CI, or !CI in SUB mode.
- Pipeline register k holds:
  - valid bit;
  - sum bits completed so far;
  - the not-yet-added upper X and Y bits, with Y already conditionally inverted;
  - the segment carry-out.
- Operands for a beat are captured once at acceptance. Later changes on X, Y, CI or SUB do not affect in-flight beats.
- Handshake, per stage:
  - ready[k] = !valid[k] | ready[k+1], with ready[STAGES] = OUT_READY.
  - IN_READY = ready[0], which is combinational from the valid bits and OUT_READY.
  - Register k loads when ready[k]. Its valid bit takes the upstream valid; IN_VALID for stage 0.
- Acceptance: a beat is accepted when IN_VALID & IN_READY. It is consumed when OUT_VALID & OUT_READY.
- OUT_VALID = valid[STAGES-1]. S = the final register's sum and carry.
- S holds stable while OUT_VALID & !OUT_READY.
- Results leave in acceptance order; there is no drop and no duplication.
- Bubbles (stages with valid = 0) collapse under backpressure: a stalled output does not block an empty upstream stage.

## Timing
- Latency: a beat accepted at edge n gives OUT_VALID high after edge n+STAGES-1, with OUT_READY held 1.
- STAGES=1 gives one register cycle.
- Throughput: one beat per cycle while OUT_READY = 1.
- Capacity: STAGES beats in flight. With OUT_READY = 0, IN_READY falls once all stages are valid.
- Simultaneous events: a full pipeline with OUT_READY = 1 accepts a new beat in the same cycle the oldest leaves.
- Reset (RSTn low, asynchronous):
  - all valid bits clear immediately; OUT_VALID = 0;
  - S = 0 and all data registers = 0;
  - IN_READY = 1, since the stages are empty.
  - RSTn low mid-operation discards every in-flight beat; nothing is emitted afterwards.
  - Release is synchronous to CLK. The first beat can be accepted at the first edge with RSTn high.
- Longest combinational path: one segment ripple, ceil(WIDTH/STAGES) cells, plus the ready chain across STAGES.

## Test plan
- Maximum add (WIDTH=27, STAGES=3): X=27'h7FFFFFF, Y=0, CI=1, SUB=0.
  - Required: S=28'h8000000, with OUT_VALID exactly 3 edges after acceptance.
  - Confirms carry propagation through both segment boundaries.
- Subtract (WIDTH=27, STAGES=3), two beats back-to-back:
  - X=5, Y=7, CI=0, SUB=1 → S=28'h7FFFFFE (borrow, S[27]=0).
  - X=7, Y=5, CI=0, SUB=1 → S=28'h8000002.
  - Both results must appear on consecutive cycles.
- Backpressure: stream 10 random beats while OUT_READY toggles 1,0,0,1,…
  - IN_READY must drop only after 3 undelivered beats.
  - Results match a golden model, in order, with none lost or duplicated.
  - S is stable while stalled.
- Bubble collapse: accept 1 beat, hold OUT_READY=0 for 5 cycles, then offer 2 more.
  - Both new beats must be accepted before OUT_READY rises.
- Reset mid-stream: assert RSTn low asynchronously with 3 beats in flight.
  - OUT_VALID=0 and S=0 before the next edge; IN_READY=1.
  - After release, no stale result is emitted.
- Parameter sweep: WIDTH ∈ {2,9,27,64} × STAGES ∈ {1,4,WIDTH}, 1000 random ADD/SUB beats each with random CI.
  - All results exact versus the model; latency equals STAGES.
